program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction memory. Receives a byte stream over a valid/ready handshake and assembles it into little-endian 32-bit words.
- Writes each word through a synchronous single-word write port into instruction memory, starting at BASE_ADDR.
- Holds the core in reset until the image is loaded and its checksum verifies.
- Replaces the file-preload path so program images can be loaded at run time.

Parameters:
- Size, 1024, instruction memory depth in 32-bit words; largest image accepted.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming image byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle instruction-memory write strobe.
- mem_addr  output  32  byte address of the write; word-aligned.
- mem_wdata  output  32  word being written.
- cpu_reset  output  1  hold-reset for the core; high until load succeeds.
- done  output  1  image loaded and checksum matched; sticky.
- error  output  1  load failed (oversize or checksum mismatch); sticky.

Behaviour:
- Clock and reset: single clock domain. reset is synchronous and active-high, sampled on the rising edge of clk.
- Image format, all fields little-endian (first byte is bits 7:0):
  - 4-byte word count N.
  - N data words of 4 bytes each.
  - 4-byte checksum = sum of all N data words mod 2^32.
- Byte acceptance: a byte is accepted on a rising edge where rx_valid && rx_ready. rx_ready does not depend combinationally on rx_valid.
- States: HEADER, DATA, CHECK, DONE, ERROR.
- Reset values:
  - State HEADER; byte index 0; word index 0; checksum accumulator 0.
  - Outputs: rx_ready=1 (combinational from state), mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_reset=1, done=0, error=0.
- rx_ready is 1 in HEADER, DATA and CHECK, and 0 in DONE and ERROR.
- Byte assembly: a 2-bit byte index selects the lane. The accepted byte goes to bits [8*idx+7 : 8*idx] of a shift/assembly register. The index wraps 3→0 on the fourth accepted byte.
- HEADER: on the 4th accepted byte, latch N.
  - N > Size → ERROR.
  - N == 0 → CHECK.
  - Otherwise → DATA.
- DATA, on the 4th byte of each word, in the next cycle:
  - mem_we=1 for exactly one cycle.
  - mem_addr = BASE_ADDR + 4*word_index (32-bit wrap).
  - mem_wdata = assembled word.
  - The accumulator adds the word (mod 2^32) and word_index increments.
  - Write latency: 1 cycle after the accepting edge.
  - When the last (Nth) word is accepted, transition → CHECK.
- DATA while idle: mem_we stays 0 when no word completes. mem_addr and mem_wdata hold their last values.
- CHECK: on the 4th accepted byte, compare with the accumulator, which already includes the final word because its write strobe precedes any CHECK byte.
  - Equal → DONE.
  - Not equal → ERROR.
- DONE: done=1 and cpu_reset=0, both registered, first visible the cycle after the final checksum byte is accepted. Sticky until reset.
- ERROR: error=1 (registered, visible the cycle after the offending byte). cpu_reset stays 1. Sticky until reset.
- done and error are never both 1.
- Gaps: rx_valid may drop at any point, including between bytes of a word. All state holds; no timeout.
- Reset mid-load: returns to HEADER with counters and accumulator cleared, and cpu_reset=1. Words already written remain in memory, and there is no further mem_we. A reset on the same edge as a byte handshake discards the byte.
- Arithmetic: word_index is $clog2(Size+1) bits; N is compared at full 32 bits. Checksum addition is 32 bits with carry discarded.

Test Plan:
- Normal load:
  - Stimulus: header 02 00 00 00; words 13 05 10 00 (0x00100513) and 93 05 20 00 (0x00200593); checksum 0x00300AA6 sent as A6 0A 30 00.
  - Response: mem_we pulses at addr 0x0 data 0x00100513, then addr 0x4 data 0x00200593.
  - Response: done=1 and cpu_reset=0 one cycle after the last byte; rx_ready=0 afterward.
- Empty image:
  - Stimulus: header 00 00 00 00, checksum 00 00 00 00.
  - Response: no mem_we; done=1.
- Oversize:
  - Stimulus: header 01 04 00 00 (N=1025, Size=1024).
  - Response: error=1 one cycle after the 4th byte; rx_ready=0; cpu_reset=1; no mem_we.
- Bad checksum:
  - Stimulus: the normal image with checksum A7 0A 30 00.
  - Response: both words written; error=1, done=0, cpu_reset=1.
- Stalled stream:
  - Stimulus: the normal image with rx_valid deasserted for 3 cycles between every byte.
  - Response: identical writes and done, each mem_we exactly one cycle wide.
- Reset mid-load:
  - Stimulus: assert reset after 1 data word, then send the full normal image.
  - Response: after the reset edge, state is HEADER with cpu_reset=1. The reload writes addr 0x0 first and ends with done=1.

Source files
------------

// File: rtl/program_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into words,
// writes them from BASE_ADDR, verifies the checksum, then releases the core.
module program_loader #(
  parameter int          Size      = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam int          IDX_W  = $clog2(Size + 1);
  localparam logic [31:0] SIZE_W = 32'(Size);

  typedef enum logic [2:0] {HEADER, DATA, CHECK, DONE, ERROR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_asm;
  logic [31:0]       r_n;
  logic [31:0]       r_sum;
  logic [IDX_W-1:0]  r_word_idx;

  logic              w_accept;
  logic              w_word_done;
  logic              w_last_data;
  logic [31:0]       w_word;

  // The top byte of a word never needs storing: it arrives on the completing edge.
  assign w_accept    = rx_valid && rx_ready;
  assign w_word_done = w_accept && (r_byte_idx == 2'd3);
  assign w_word      = {rx_data, r_asm};
  assign w_last_data = ((32'(r_word_idx) + 32'd1) == r_n);

  always_comb begin
    rx_ready = 1'b0;
    case (r_state)
      HEADER, DATA, CHECK: rx_ready = 1'b1;
      default:             rx_ready = 1'b0;
    endcase
  end

  assign done      = (r_state == DONE);
  assign error     = (r_state == ERROR);
  assign cpu_reset = (r_state != DONE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= HEADER;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HEADER: if (w_word_done) begin
        if (w_word > SIZE_W)      w_next = ERROR;
        else if (w_word == 32'd0) w_next = CHECK;
        else                      w_next = DATA;
      end
      DATA:   if (w_word_done && w_last_data) w_next = CHECK;
      CHECK:  if (w_word_done) w_next = (w_word == r_sum) ? DONE : ERROR;
      DONE:   w_next = DONE;
      ERROR:  w_next = ERROR;
      default: w_next = HEADER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_idx <= 2'd0;
      r_asm      <= 24'd0;
      r_n        <= 32'd0;
      r_sum      <= 32'd0;
      r_word_idx <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if (w_accept) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        case (r_byte_idx)
          2'd0:    r_asm[7:0]   <= rx_data;
          2'd1:    r_asm[15:8]  <= rx_data;
          2'd2:    r_asm[23:16] <= rx_data;
          default: ;
        endcase
      end
      if (w_word_done) begin
        case (r_state)
          HEADER: r_n <= w_word;
          DATA: begin
            mem_we     <= 1'b1;
            mem_addr   <= BASE_ADDR + (32'(r_word_idx) << 2);
            mem_wdata  <= w_word;
            r_sum      <= r_sum + w_word;
            r_word_idx <= r_word_idx + IDX_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a byte-count based image model predicts
// every output each cycle; directed images pin the model with literal values.
module tb_program_loader;

  localparam int          SIZE = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready, mem_we, cpu_reset, done, error;
  logic [31:0] mem_addr, mem_wdata;

  program_loader #(.Size(SIZE), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: counts accepted bytes and interprets them as the image.
  longint      m_cnt;
  logic [31:0] m_n, m_sum, m_cur;
  int          m_status;  // 0 loading, 1 done, 2 error
  logic        e_we;
  logic [31:0] e_addr, e_wdata;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0; m_sum = 0; m_n = 0; m_cur = 0; m_status = 0;
      e_we = 0; e_addr = BASE; e_wdata = 0;
    end else begin
      e_we = 0;
      if (rx_valid && m_status == 0) begin
        m_cur[8*(m_cnt%4) +: 8] = rx_data;
        m_cnt++;
        if (m_cnt % 4 == 0) begin
          longint w;
          w = m_cnt / 4;
          if (w == 1) begin
            m_n = m_cur;
            if (longint'(m_n) > SIZE) m_status = 2;
          end else if (w - 2 < longint'(m_n)) begin
            e_we = 1;
            e_addr = BASE + 32'((w - 2) * 4);
            e_wdata = m_cur;
            m_sum = m_sum + m_cur;
          end else begin
            m_status = (m_cur == m_sum) ? 1 : 2;
          end
        end
      end
    end
  end

  // Per-cycle compare plus a log of DUT writes for the directed checks.
  logic [63:0] wlog[$];
  always @(posedge clk) begin
    #2;
    chk("rx_ready", 32'(rx_ready), 32'(m_status == 0));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("done", 32'(done), 32'(m_status == 1));
    chk("error", 32'(error), 32'(m_status == 2));
    chk("cpu_reset", 32'(cpu_reset), 32'(m_status != 1));
    if (mem_we) wlog.push_back({mem_addr, mem_wdata});
  end

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); rx_valid = 1'b0; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] img[$];

  // Sends header, img words, and checksum (+1 if bad); gap<0 means random gaps.
  task automatic send_image(input bit bad, input int gap);
    logic [31:0] s;
    s = 0;
    foreach (img[i]) s += img[i];
    send_word(32'(img.size()), gap < 0 ? $urandom_range(0, 2) : gap);
    foreach (img[i]) send_word(img[i], gap < 0 ? $urandom_range(0, 2) : gap);
    send_word(bad ? s + 32'd1 : s, gap < 0 ? $urandom_range(0, 2) : gap);
    idle(3);
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_wcount"}, 32'(wlog.size()), 32'(img.size()));
    foreach (wlog[i]) if (i < img.size()) begin
      chk({nm, "_addr"}, wlog[i][63:32], BASE + 32'(i * 4));
      chk({nm, "_data"}, wlog[i][31:0], img[i]);
    end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", 32'(rx_ready), 32'd1);
    chk("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reset_addr", mem_addr, BASE);

    // Normal load
    wlog.delete(); img = '{32'h00100513, 32'h00200593};
    send_image(1'b0, 0);
    chk("norm_sum", m_sum, 32'h00300AA6);
    chk("norm_w0", wlog[0][31:0], 32'h00100513);
    chk("norm_a1", wlog[1][63:32], 32'h4);
    chk("norm_w1", wlog[1][31:0], 32'h00200593);
    chk("norm_done", 32'(done), 32'd1);
    chk("norm_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("norm_ready", 32'(rx_ready), 32'd0);
    check_log("norm");

    // Empty image
    do_reset(); wlog.delete(); img.delete();
    send_image(1'b0, 0);
    chk("empty_wcount", 32'(wlog.size()), 32'd0);
    chk("empty_done", 32'(done), 32'd1);

    // Oversize header, then extra bytes that must be refused
    do_reset(); wlog.delete();
    send_word(32'h0000_0401, 0);
    send_word(32'hDEAD_BEEF, 0);
    idle(2);
    chk("over_error", 32'(error), 32'd1);
    chk("over_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("over_ready", 32'(rx_ready), 32'd0);
    chk("over_wcount", 32'(wlog.size()), 32'd0);

    // Bad checksum
    do_reset(); wlog.delete(); img = '{32'h00100513, 32'h00200593};
    send_image(1'b1, 0);
    check_log("bad");
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_done", 32'(done), 32'd0);

    // Stalled stream
    do_reset(); wlog.delete();
    send_image(1'b0, 3);
    check_log("stall");
    chk("stall_done", 32'(done), 32'd1);

    // Reset mid-load, with a byte offered on the reset edge
    do_reset(); wlog.delete();
    send_word(32'd2, 0);
    send_word(32'h00100513, 0);
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h02;
    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0;
    chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    wlog.delete();
    send_image(1'b0, 1);
    check_log("mid");
    chk("mid_done", 32'(done), 32'd1);

    // Random images
    for (int t = 0; t < 20; t++) begin
      bit bad;
      int len;
      do_reset(); wlog.delete(); img.delete();
      len = $urandom_range(1, 6);
      bad = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) img.push_back($urandom);
      send_image(bad, -1);
      check_log("rand");
      chk("rand_done", 32'(done), 32'(!bad));
      chk("rand_error", 32'(error), 32'(bad));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
